// File: rtl/schedule_writer_pkg.sv
`default_nettype none
// ------------------------------------------------------------------------
// schedule_writer_pkg: shared sizes, state codes and entry helpers, rev 1.0
// ------------------------------------------------------------------------
package schedule_writer_pkg;

  localparam int DEPTH   = 16;
  localparam int ENTRY_W = 8;
  localparam int ADDR_W  = $clog2(DEPTH);
  localparam int CNT_W   = ADDR_W + 1;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_WRITE = 2'd1;
  localparam state_t ST_CLEAR = 2'd2;

  localparam logic [ENTRY_W-1:0] EMPTY_ENTRY = 8'h00;

  function automatic logic [3:0] entry_id(input logic [ENTRY_W-1:0] e);
    return e[7:4];
  endfunction

  function automatic logic [3:0] entry_dur(input logic [ENTRY_W-1:0] e);
    return e[3:0];
  endfunction

  // A slot holds a prescription only when its duration is nonzero.
  function automatic logic entry_valid(input logic [ENTRY_W-1:0] e);
    return entry_dur(e) != 4'd0;
  endfunction

endpackage
`default_nettype wire

// File: rtl/schedule_writer_mem.sv
`default_nettype none
// ------------------------------------------------------------------------
// schedule_mem: register array, one write port, registered read, rev 1.0
// ------------------------------------------------------------------------
module schedule_mem
  import schedule_writer_pkg::*;
#(
  parameter int MEM_DEPTH = 16,
  parameter int MEM_W     = 8,
  parameter int MEM_AW    = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [MEM_AW-1:0] waddr,
  input  logic [MEM_W-1:0]  wdata,
  output logic [MEM_W-1:0]  wold,
  input  logic [MEM_AW-1:0] raddr,
  output logic [MEM_W-1:0]  rdata
);

  logic [MEM_W-1:0] mem_q [MEM_DEPTH];
  logic [MEM_W-1:0] mem_d [MEM_DEPTH];
  logic [MEM_W-1:0] rdata_q, rdata_d;

  // Reads sample the pre-edge array, so a same-slot write is not visible yet.
  always_comb begin
    mem_d = mem_q;
    if (we) mem_d[waddr] = wdata;
    rdata_d = mem_q[raddr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MEM_DEPTH; i++) mem_q[i] <= '0;
      rdata_q <= '0;
    end else begin
      mem_q   <= mem_d;
      rdata_q <= rdata_d;
    end
  end

  assign wold  = mem_q[waddr];
  assign rdata = rdata_q;

endmodule
`default_nettype wire

// File: rtl/schedule_writer.sv
`default_nettype none
// ------------------------------------------------------------------------
// schedule_writer: run-time programmable schedule store with count, rev 1.0
// ------------------------------------------------------------------------
module schedule_writer
  import schedule_writer_pkg::*;
#(
  parameter int DEPTH   = schedule_writer_pkg::DEPTH,
  parameter int ENTRY_W = schedule_writer_pkg::ENTRY_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [ENTRY_W-1:0]       wr_entry,
  input  logic                     write_pulse,
  input  logic                     clear_pulse,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [ENTRY_W-1:0]       rd_data,
  output logic                     busy,
  output logic                     wr_ack,
  output logic                     wr_rej,
  output logic [$clog2(DEPTH):0]   entry_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  state_t             state_q, state_d;
  logic [AW-1:0]      hold_addr_q, hold_addr_d;
  logic [ENTRY_W-1:0] hold_entry_q, hold_entry_d;
  logic [AW-1:0]      clr_ptr_q, clr_ptr_d;
  logic [CW-1:0]      count_q, count_d;
  logic               wr_ack_q, wr_ack_d;
  logic               wr_rej_q, wr_rej_d;

  logic               mem_we;
  logic [AW-1:0]      mem_waddr;
  logic [ENTRY_W-1:0] mem_wdata;
  logic [ENTRY_W-1:0] mem_old;
  logic               old_valid, new_valid;

  always_comb begin
    state_d      = state_q;
    hold_addr_d  = hold_addr_q;
    hold_entry_d = hold_entry_q;
    clr_ptr_d    = clr_ptr_q;
    count_d      = count_q;
    wr_ack_d     = 1'b0;
    wr_rej_d     = 1'b0;
    mem_we       = 1'b0;
    mem_waddr    = hold_addr_q;
    mem_wdata    = hold_entry_q;
    old_valid    = entry_valid(mem_old);
    new_valid    = entry_valid(hold_entry_q);

    case (state_q)
      ST_IDLE: begin
        // Clear has priority; a simultaneous write request is refused.
        if (clear_pulse) begin
          state_d   = ST_CLEAR;
          clr_ptr_d = '0;
          wr_rej_d  = write_pulse;
        end else if (write_pulse) begin
          hold_addr_d  = wr_addr;
          hold_entry_d = wr_entry;
          state_d      = ST_WRITE;
        end
      end

      ST_WRITE: begin
        mem_we   = 1'b1;
        wr_ack_d = 1'b1;
        wr_rej_d = write_pulse;
        if (!old_valid && new_valid && count_q != CW'(DEPTH)) begin
          count_d = count_q + 1'b1;
        end else if (old_valid && !new_valid && count_q != '0) begin
          count_d = count_q - 1'b1;
        end
        state_d = ST_IDLE;
      end

      ST_CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = clr_ptr_q;
        mem_wdata = EMPTY_ENTRY;
        clr_ptr_d = clr_ptr_q + 1'b1;
        wr_rej_d  = write_pulse;
        if (clr_ptr_q == AW'(DEPTH - 1)) begin
          count_d = '0;
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      hold_addr_q  <= '0;
      hold_entry_q <= '0;
      clr_ptr_q    <= '0;
      count_q      <= '0;
      wr_ack_q     <= 1'b0;
      wr_rej_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_addr_q  <= hold_addr_d;
      hold_entry_q <= hold_entry_d;
      clr_ptr_q    <= clr_ptr_d;
      count_q      <= count_d;
      wr_ack_q     <= wr_ack_d;
      wr_rej_q     <= wr_rej_d;
    end
  end

  schedule_mem #(
    .MEM_DEPTH (DEPTH),
    .MEM_W     (ENTRY_W),
    .MEM_AW    (AW)
  ) u_mem (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (mem_we),
    .waddr (mem_waddr),
    .wdata (mem_wdata),
    .wold  (mem_old),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  assign busy        = (state_q != ST_IDLE);
  assign wr_ack      = wr_ack_q;
  assign wr_rej      = wr_rej_q;
  assign entry_count = count_q;

endmodule
`default_nettype wire

// File: doc/schedule_writer.md
# schedule_writer

Writable prescription schedule store: captures `{id, duration}` entries from the toggle switches into a 16-slot table on a shaped button pulse, and serves them to the control block through a synchronous read port with the same one-cycle latency as the existing ROM. It is the writer side of the schedule lookup. The control block keeps reading by address, while this block lets the user program, overwrite and clear entries at run time. It also tracks how many slots hold a valid prescription.

## Interface

Parameters:
- `DEPTH`, 16: number of schedule slots; must be a power of two.
- `ENTRY_W`, 8: entry width, `{id[7:4], duration[3:0]}`.

Ports:
- `clk`, in, 1: system clock, the same clock that feeds the control block.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `wr_addr`, in, 4: target slot, taken from toggle switches 17..14.
- `wr_entry`, in, 8: entry to store, taken from toggle switches 13..6.
- `write_pulse`, in, 1: one-cycle pulse from the Set button shaper.
- `clear_pulse`, in, 1: one-cycle pulse from the Reset button shaper.
- `rd_addr`, in, 4: read slot, driven by the control block.
- `rd_data`, out, 8: registered read data.
- `busy`, out, 1: high while a write or clear is in progress.
- `wr_ack`, out, 1: one-cycle pulse when a write has committed.
- `wr_rej`, out, 1: one-cycle pulse when a write request was refused.
- `entry_count`, out, 5: number of valid slots, range 0..16.

## Operation

- A slot is valid when its duration field is nonzero. `8'h00` means an empty slot.
- The state machine has three states: IDLE, WRITE and CLEAR.
- IDLE, `write_pulse` only: latch `wr_addr` and `wr_entry` into holding registers, then go to WRITE.
- IDLE, `clear_pulse` (with or without `write_pulse`): go to CLEAR and reset the clear pointer to 0.
  - If `write_pulse` was also high, pulse `wr_rej`. Clear wins.
- WRITE, one cycle:
  - Store the held entry into the held slot and pulse `wr_ack`.
  - Update `entry_count` using the old and new validity of that slot:
    - empty to valid: +1
    - valid to empty: −1
    - otherwise: unchanged
  - Return to IDLE.
- CLEAR, 16 cycles:
  - Write `8'h00` to the slot at the pointer, then increment the pointer.
  - After slot 15, set `entry_count` to 0 and return to IDLE.
- Any `write_pulse` in WRITE or CLEAR causes a `wr_rej` pulse and is otherwise dropped.
- Any `clear_pulse` in WRITE or CLEAR is ignored silently.
- Writing an entry with a nonzero id and zero duration is legal. It empties the slot.
- Reads are independent of the state machine. `rd_data` shows the contents of slot `rd_addr` as of the previous edge.

## Timing

Reset (asynchronous, on `rst_n` low):
- All 16 slots are set to 0.
- `rd_data` = 0, `busy` = 0, `wr_ack` = 0, `wr_rej` = 0, `entry_count` = 0.
- State returns to IDLE.
- Asserting `rst_n` in the middle of a WRITE or CLEAR aborts it. No partial count survives.

Write latency:
- `write_pulse` is sampled at edge E0.
- The slot and `entry_count` update at edge E1.
- `wr_ack` is high for the cycle after E1.
- `busy` is high for the cycle between E0 and E1.

Read latency:
- `rd_addr` is sampled at edge E.
- `rd_data` is valid after E, one cycle, matching the ROM.
- Read and write to the same slot at the same edge: `rd_data` returns the old contents (read-before-write). The new contents appear on the next read.

Clear timing:
- `busy` is high for exactly 16 cycles.
- `entry_count` reaches 0 at the edge that clears slot 15.

Other cycle-level rules:
- `wr_rej` is high for exactly the cycle after the offending pulse is sampled.
- Two back-to-back write pulses: the second lands in WRITE and is rejected.
- `entry_count` never exceeds 16 and never wraps below 0.

## Structure

- Shared package holds:
  - `DEPTH`, `ENTRY_W`
  - the state enum (IDLE, WRITE, CLEAR)
  - the empty-entry constant `8'h00`
  - field slice helpers for id and duration
- One sub-module, `schedule_mem`:
  - 16×8 register array with asynchronous reset.
  - One write port and one registered read port with read-before-write behaviour.
- The state machine, holding registers and counter stay in `schedule_writer`.

## Test plan

- Reset, then write `8'h32` to slot 5 → `wr_ack` one cycle after E1; `entry_count` = 1; reading slot 5 returns `8'h32` one cycle later.
- Overwrite slot 5 with `8'h30` → `entry_count` goes 1 → 0; slot 5 reads `8'h30`. Then write `8'h00` to slot 5 → `entry_count` stays 0.
- Fill all 16 slots with nonzero durations, then pulse `clear_pulse` → `busy` high for 16 cycles; every slot reads `8'h00`; `entry_count` = 0.
- During a clear, pulse `write_pulse` at clear cycle 3 → `wr_rej` one cycle later; no slot ends nonzero. Also apply `write_pulse` and `clear_pulse` in the same IDLE cycle → `wr_rej` pulses and the clear runs.
- Two consecutive `write_pulse` cycles to slots 1 and 2 → slot 1 written with `wr_ack`; slot 2 rejected with `wr_rej`; slot 2 still reads `8'h00`.
- Drop `rst_n` at clear cycle 8 after the slots were filled → all outputs 0 immediately; all slots read `8'h00`; state is IDLE.
